// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial add/sub controller:
//   - NIBBLE_W : width of one adder slice (4 bits)
//   - state_e  : controller FSM states
//   - idx_width: width of the nibble index register for a given nibble count
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-nibble operand still needs a one-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_four_bit_adder.sv
// ---------------------------------------------------------------------------
// FourBitAdder
// Plain 4-bit ripple-carry adder used as the shared datapath slice.
// Ports:
//   a, b  in  4  addends
//   cin   in  1  carry-in
//   sum   out 4  a + b + cin (low 4 bits)
//   cout  out 1  carry out of bit 3
// ---------------------------------------------------------------------------
module FourBitAdder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds or subtracts two NIBBLES*4-bit operands one nibble per clock,
// least significant nibble first, through a single shared FourBitAdder.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   start  in  1  request; accepted only in IDLE or DONE
//   op_a   in  W  operand A (sampled on the accepting edge)
//   op_b   in  W  operand B (sampled on the accepting edge)
//   sub    in  1  0: A+B+cin, 1: A-B-cin
//   cin    in  1  carry-in / borrow-in
//   busy   out 1  high while the nibbles are being processed
//   done   out 1  one-cycle result-valid pulse
//   sum    out W  result, partial while busy
//   cout   out 1  final carry (for sub, 1 = no borrow)
//   ovf    out 1  two's-complement overflow of the W-bit result
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    input  logic                       sub,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_nibbles
        $error("nibble_serial_adder_ctrl: NIBBLES must be in 1..16");
    end

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] add_x, add_y, add_s;
    logic                add_co;

    FourBitAdder u_adder (
        .a    (add_x),
        .b    (add_y),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_x   = '0;
        add_y   = '0;

        // Constant-index mux keeps the nibble select free of out-of-range slices.
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                add_x = a_q[NIBBLE_W*i +: NIBBLE_W];
                add_y = b_q[NIBBLE_W*i +: NIBBLE_W];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + ~cin, so the borrow-in inverts.
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[NIBBLE_W*i +: NIBBLE_W] = add_s;
                    end
                end
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The last slice holds the sign bit of the result.
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[NIBBLE_W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Self-checking bench for nibble_serial_adder_ctrl with NIBBLES = 4.
// Expected results come from integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;
    int cycle;
    int doneCycle;

    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .sub   (sub),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to measure done spacing
    always @(posedge clk) cycle <= cycle + 1;

    // Single comparison with counting and reporting
    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a request and compute its expected result from plain arithmetic
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
        int ua, ub, sa, sb, ru, rs;
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        if (s) begin
            ru = ua - ub - int'(c);
            rs = sa - sb - int'(c);
            expCout = (ru >= 0);
        end else begin
            ru = ua + ub + int'(c);
            rs = sa + sb + int'(c);
            expCout = (ru > 65535);
        end
        expSum = ru[W-1:0];
        expOvf = (rs > 32767) || (rs < -32768);
    endtask

    // Follow one operation from the accepting edge to its done cycle.
    // With noise set, start and operands are scrambled throughout RUN.
    task automatic checkOutput(input string tag, input bit noise);
        logic [W-1:0] mask;
        @(posedge clk); #1;
        for (int k = 0; k <= N; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k < N) begin
                mask = (k == 0) ? '0 : W'((32'h1 << (4 * k)) - 1);
                checkValue({tag, " busy"}, 32'(busy), 32'd1);
                checkValue({tag, " done-low"}, 32'(done), 32'd0);
                checkValue({tag, " partial"}, 32'(sum), 32'(expSum & mask));
                if (noise) begin
                    start = 1'b1;
                    op_a  = W'($urandom);
                    op_b  = W'($urandom);
                    sub   = 1'($urandom);
                    cin   = 1'($urandom);
                end else begin
                    start = 1'b0;
                end
            end else begin
                checkValue({tag, " done"}, 32'(done), 32'd1);
                checkValue({tag, " busy-low"}, 32'(busy), 32'd0);
                checkValue({tag, " sum"}, 32'(sum), 32'(expSum));
                checkValue({tag, " cout"}, 32'(cout), 32'(expCout));
                checkValue({tag, " ovf"}, 32'(ovf), 32'(expOvf));
                start     = 1'b0;
                doneCycle = cycle;
            end
        end
    endtask

    // One cycle after done with no start: back to IDLE, result held
    task automatic checkIdle(input string tag);
        @(posedge clk); #1;
        checkValue({tag, " idle-done"}, 32'(done), 32'd0);
        checkValue({tag, " idle-busy"}, 32'(busy), 32'd0);
        checkValue({tag, " hold-sum"}, 32'(sum), 32'(expSum));
    endtask

    initial begin
        int prevDone;
        logic [W-1:0] ra, rb;
        bit btb;
        checks    = 0;
        errors    = 0;
        cycle     = 0;
        doneCycle = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        cin       = 1'b0;

        // Reset state
        #3;
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset done", 32'(done), 32'd0);
        checkValue("reset sum", 32'(sum), 32'd0);
        checkValue("reset cout", 32'(cout), 32'd0);
        checkValue("reset ovf", 32'(ovf), 32'd0);
        #9 rst_n = 1'b1;

        // Directed arithmetic cases
        @(posedge clk); #1;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOutput("add1234", 1'b0);
        checkIdle("add1234");

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("carrychain", 1'b0);
        checkIdle("carrychain");

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("ovfpos", 1'b0);
        checkIdle("ovfpos");

        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
        checkOutput("ovfneg", 1'b0);
        checkIdle("ovfneg");

        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0);
        checkOutput("sub5m7", 1'b0);
        checkIdle("sub5m7");

        applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1);
        checkOutput("subborrow", 1'b0);
        checkIdle("subborrow");

        // start pulsed every RUN cycle with changing operands
        applyStimulus(16'hA5A5, 16'h1111, 1'b0, 1'b1);
        checkOutput("ignorerun", 1'b1);

        // start held in DONE: back-to-back, done pulses 5 cycles apart
        prevDone = doneCycle;
        applyStimulus(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        checkOutput("backtoback", 1'b0);
        checkValue("done spacing", 32'(doneCycle - prevDone), 32'd5);
        checkIdle("backtoback");

        // Leave cout/ovf at 1 so the reset clearing is observable
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
        checkOutput("prereset", 1'b0);
        checkIdle("prereset");

        // Asynchronous reset with idx = 2
        applyStimulus(16'h1357, 16'h2468, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkValue("midrun busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async busy", 32'(busy), 32'd0);
        checkValue("async done", 32'(done), 32'd0);
        checkValue("async sum", 32'(sum), 32'd0);
        checkValue("async cout", 32'(cout), 32'd0);
        checkValue("async ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkValue("postreset idle", 32'(busy), 32'd0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
        checkOutput("postreset", 1'b0);
        checkIdle("postreset");

        // Randomized operations, some noisy, some back-to-back
        btb = 1'b0;
        for (int t = 0; t < 24; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (t % 6 == 0) rb = ~ra;
            prevDone = doneCycle;
            applyStimulus(ra, rb, 1'($urandom), 1'($urandom));
            checkOutput("random", 1'($urandom));
            if (btb) begin
                checkValue("random spacing", 32'(doneCycle - prevDone), 32'd5);
            end
            btb = 1'($urandom);
            if (!btb) begin
                checkIdle("random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
